// File: rtl/itof_pipe.sv
// -----------------------------------------------------------------------------
// itof_pipe : three-stage pipelined integer -> IEEE-754 binary32 converter.
//
// Stages
//   S1 : sign extraction, magnitude, leading-one index
//   S2 : left-normalise so the leading one sits at the MSB (the one is dropped)
//   S3 : round (RNE or RTZ) and pack into out_* registers
// Each stage loads when it is empty or when the stage after it moves on, so a
// stall at the output freezes every payload in place.
//
// Ports
//   clk, rstn            clock / asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_data [INT_W]      integer operand
//   in_uns               1: unsigned operand, 0: two's complement
//   in_rm                0: round to nearest even, 1: round toward zero
//   in_tag  [TAG_W]      opaque tag carried with the operation
//   out_valid/out_ready  output handshake
//   out_data [32]        binary32 result
//   out_tag  [TAG_W]     tag of the result
//   out_nx               inexact flag (only when ITOF_FLAGS_EN is defined)
//
// Build option: define ITOF_FLAGS_EN to add the out_nx output.
// -----------------------------------------------------------------------------
module itof_pipe #(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  input  logic             in_uns,
  input  logic             in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef ITOF_FLAGS_EN
  ,
  output logic             out_nx
`endif
);

  localparam int EW = $clog2(INT_W);

  // Stage ready chain
  logic s1_ready_s, s2_ready_s, s3_ready_s;

  // S1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_rm_q, s1_rm_d;
  logic [INT_W-1:0] s1_abs_q, s1_abs_d;
  logic [EW-1:0]    s1_e_q, s1_e_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // S2 state (fraction excludes the implicit leading one)
  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q, s2_sign_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_rm_q, s2_rm_d;
  logic [INT_W-2:0] s2_frac_q, s2_frac_d;
  logic [EW-1:0]    s2_e_q, s2_e_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  // Output state
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_nx_q, out_nx_d;

  // S1 combinational helpers
  logic             sign_s;
  logic [INT_W-1:0] abs_s;
  logic [EW-1:0]    lead_s;
  // S2 helper
  logic [EW-1:0]    shamt_s;
  // S3 helpers
  logic [INT_W+22:0] ext_s;
  logic [22:0]       mant_s, mant_r_s;
  logic              g_s, st_s, inc_s, carry_s;
  logic [7:0]        exp_s;

  // Handshake: each stage can load when empty or when its successor drains it.
  always_comb begin
    s3_ready_s = ~out_valid_q | out_ready;
    s2_ready_s = ~s2_valid_q | s3_ready_s;
    s1_ready_s = ~s1_valid_q | s2_ready_s;
    in_ready   = s1_ready_s;
  end

  // S1 datapath: sign, magnitude (most negative value maps to 2^(INT_W-1)), leading one.
  always_comb begin
    sign_s = in_data[INT_W-1] & ~in_uns;
    abs_s  = sign_s ? (~in_data + INT_W'(1)) : in_data;
    lead_s = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (abs_s[i]) begin
        lead_s = EW'(i);
      end else begin
        lead_s = lead_s;
      end
    end
  end

  // S1 next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_rm_d    = s1_rm_q;
    s1_abs_d   = s1_abs_q;
    s1_e_d     = s1_e_q;
    s1_tag_d   = s1_tag_q;
    if (s1_ready_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = sign_s;
        s1_zero_d = (in_data == '0);
        s1_rm_d   = in_rm;
        s1_abs_d  = abs_s;
        s1_e_d    = lead_s;
        s1_tag_d  = in_tag;
      end else begin
        s1_tag_d  = s1_tag_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 next state: shift the leading one up to bit INT_W-1 and drop it.
  always_comb begin
    shamt_s    = EW'(INT_W - 1) - s1_e_q;
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_rm_d    = s2_rm_q;
    s2_frac_d  = s2_frac_q;
    s2_e_d     = s2_e_q;
    s2_tag_d   = s2_tag_q;
    if (s2_ready_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d = s1_sign_q;
        s2_zero_d = s1_zero_q;
        s2_rm_d   = s1_rm_q;
        s2_frac_d = (INT_W-1)'(s1_abs_q << shamt_s);
        s2_e_d    = s1_e_q;
        s2_tag_d  = s1_tag_q;
      end else begin
        s2_tag_d  = s2_tag_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // S3: round and pack. Padding below the fraction lets narrow INT_W share the same slicing.
  always_comb begin
    ext_s   = {s2_frac_q, 24'd0};
    mant_s  = ext_s[INT_W+22 -: 23];
    g_s     = ext_s[INT_W-1];
    st_s    = |ext_s[INT_W-2:0];
    inc_s   = ~s2_rm_q & g_s & (st_s | mant_s[0]);
    {carry_s, mant_r_s} = {1'b0, mant_s} + {23'd0, inc_s};
    exp_s   = 8'd127 + 8'(s2_e_q) + {7'd0, carry_s};

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_nx_d    = out_nx_q;
    if (s3_ready_s) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        // Zero has no leading one; force +0 and a clean flag.
        out_data_d = s2_zero_q ? 32'h0000_0000 : {s2_sign_q, exp_s, mant_r_s};
        out_nx_d   = s2_zero_q ? 1'b0 : (g_s | st_s);
        out_tag_d  = s2_tag_q;
      end else begin
        out_tag_d  = out_tag_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; reset discards every in-flight operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_rm_q     <= 1'b0;
      s1_abs_q    <= '0;
      s1_e_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_rm_q     <= 1'b0;
      s2_frac_q   <= '0;
      s2_e_q      <= '0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_tag_q   <= '0;
      out_nx_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_rm_q     <= s1_rm_d;
      s1_abs_q    <= s1_abs_d;
      s1_e_q      <= s1_e_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_rm_q     <= s2_rm_d;
      s2_frac_q   <= s2_frac_d;
      s2_e_q      <= s2_e_d;
      s2_tag_q    <= s2_tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_nx_q    <= out_nx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
`ifdef ITOF_FLAGS_EN
  assign out_nx    = out_nx_q;
`else
  logic unused_nx_s;
  assign unused_nx_s = out_nx_q;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// -----------------------------------------------------------------------------
// tb_itof_pipe : directed self-checking bench for itof_pipe (INT_W=32, TAG_W=5).
// Expected results are hand-computed binary32 encodings.
// -----------------------------------------------------------------------------
module tb_itof_pipe;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_uns;
  logic        in_rm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef ITOF_FLAGS_EN
  logic        out_nx;
`endif

  int checks   = 0;
  int failures = 0;

  itof_pipe #(.INT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_uns    (in_uns),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef ITOF_FLAGS_EN
    ,
    .out_nx    (out_nx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated op with out_ready=1: checks latency, result and tag.
  task automatic run_op(input string name, input logic [31:0] d, input logic uns,
                        input logic rm, input logic [4:0] tag, input logic [31:0] exp);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_uns = uns; in_rm = rm; in_tag = tag;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, 32'(cyc), 32'd3);
    check({name, "_data"}, out_data, exp);
    check({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    @(negedge clk);
  endtask

  logic [31:0] exp_tab [8];
  logic [3:0]  pat;
  int          sent, recv, extra;
  logic        saw_stall, have_prev, acc, drn;
  logic [31:0] prev_data;
  logic [4:0]  prev_tag;

  initial begin
    exp_tab = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    rstn = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_uns = 1'b0; in_rm = 1'b0;
    in_tag = 5'd0; out_ready = 1'b1;

    // Reset state
    #23;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0000_0000);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed conversions
    run_op("one",      32'h0000_0001, 1'b0, 1'b0, 5'd1,  32'h3F80_0000);
`ifdef ITOF_FLAGS_EN
    check("one_nx", {31'd0, out_nx}, 32'd0);
`endif
    run_op("neg_one",  32'hFFFF_FFFF, 1'b0, 1'b0, 5'd2,  32'hBF80_0000);
    run_op("max_rne",  32'h7FFF_FFFF, 1'b0, 1'b0, 5'd3,  32'h4F00_0000);
    run_op("max_rtz",  32'h7FFF_FFFF, 1'b0, 1'b1, 5'd4,  32'h4EFF_FFFF);
`ifdef ITOF_FLAGS_EN
    check("max_rtz_nx", {31'd0, out_nx}, 32'd1);
`endif
    run_op("min_s",    32'h8000_0000, 1'b0, 1'b0, 5'd5,  32'hCF00_0000);
    run_op("min_u",    32'h8000_0000, 1'b1, 1'b0, 5'd6,  32'h4F00_0000);
    run_op("allone_u", 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd7,  32'h4F80_0000);
    run_op("tie_even", 32'd16777217,  1'b0, 1'b0, 5'd8,  32'h4B80_0000);
    run_op("tie_up",   32'd16777219,  1'b0, 1'b0, 5'd9,  32'h4B80_0002);
    run_op("tie_rtz",  32'd16777219,  1'b0, 1'b1, 5'd10, 32'h4B80_0001);
    run_op("zero",     32'h0000_0000, 1'b0, 1'b0, 5'd11, 32'h0000_0000);
    run_op("neg_five", 32'hFFFF_FFFB, 1'b0, 1'b0, 5'd12, 32'hC0A0_0000);
    run_op("three_u",  32'h0000_0003, 1'b1, 1'b1, 5'd13, 32'h4040_0000);

    // Back-to-back 8 ops with out_ready pattern 1,0,0,1 repeating
    pat = 4'b1001; sent = 0; recv = 0; saw_stall = 1'b0; have_prev = 1'b0;
    prev_data = 32'd0; prev_tag = 5'd0;
    in_uns = 1'b0; in_rm = 1'b0;
    for (int c = 0; c < 200 && recv < 8; c++) begin
      @(negedge clk);
      if (have_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", out_data, prev_data);
        check("hold_tag", {27'd0, out_tag}, {27'd0, prev_tag});
      end
      out_ready = pat[c % 4];
      in_valid  = (sent < 8);
      in_data   = 32'(sent + 1);
      in_tag    = 5'(16 + sent);
      #1;
      acc = in_valid & in_ready;
      drn = out_valid & out_ready;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      have_prev = out_valid & ~out_ready;
      prev_data = out_data;
      prev_tag  = out_tag;
      if (drn) begin
        check("b2b_data", out_data, exp_tab[recv]);
        check("b2b_tag", {27'd0, out_tag}, 32'(16 + recv));
        recv++;
      end
      if (acc) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    check("b2b_recv", 32'(recv), 32'd8);
    check("b2b_sent", 32'(sent), 32'd8);
    check("b2b_full_stall", {31'd0, saw_stall}, 32'd1);

    // Fill the pipe with out_ready=0, then reset mid-operation
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(100 + k); in_tag = 5'(k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    #1;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", out_data, 32'h0000_0000);
    @(negedge clk);
    rstn = 1'b1; out_ready = 1'b1;
    run_op("post_rst", 32'h0000_0002, 1'b0, 1'b0, 5'd9, 32'h4000_0000);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("post_rst_sole", 32'(extra), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
